spi_reg_slave: RTL and testbench

- SPI mode-0 slave front end for the register map.
- Deserialises a command byte and data bytes from the host. Drives the 8-bit register address and write data consumed by the read-back selector and by the write targets (gate, dac, pwm, counter blocks).
- Serialises the selector's read data back on MISO.
- Supports multi-byte bursts with address auto-increment.

---
 rtl/spi_reg_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_reg_slave.sv | 184 ++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-map slave.
// Imported by the front end and its synchroniser.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  localparam int CMD_WR_BIT = 7;
  localparam int BYTE_BITS = 8;
  localparam logic [7:0] ADDR_MASK = 8'h7F;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin,
// followed by single-clk rise/fall pulse generation.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave: command byte sets addr and direction,
// data bytes write via wr_stb and read back rd_data on MISO.
module spi_reg_slave #(
  parameter int SYNC_STAGES = 2,
  parameter bit AUTO_INC    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi_in,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] rd_data,
  output logic [7:0] addr,
  output logic [7:0] mosi,
  output logic       wr_stb,
  output logic       rd_stb,
  output logic       busy
);

  import spi_reg_pkg::*;

  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [FW-1:0] FLUSH = FW'(SYNC_STAGES);
  localparam logic [2:0] LAST = 3'(BYTE_BITS - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s;
  logic [FW-1:0] flush;
  logic armed;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] rx_nxt;
  logic [7:0] tx_q, tx_d;
  logic [7:0] addr_d, mosi_d;
  logic wrm_q, wrm_d;
  logic wr_d, rd_d;
  logic inc_q, inc_d;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sck (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sck),
    .sync (sck_lvl),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (cs_n),
    .sync (cs_lvl),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  // A frame may only start from a bus seen idle after reset,
  // so a select held low across reset is never resumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_chain <= '0;
      flush      <= '0;
      armed      <= 1'b0;
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi_in};
      if (flush != FLUSH)
        flush <= flush + FW'(1);
      if (flush == FLUSH && cs_lvl && !sck_lvl)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      addr    <= '0;
      mosi    <= '0;
      wrm_q   <= 1'b0;
      wr_stb  <= 1'b0;
      rd_stb  <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      addr    <= addr_d;
      mosi    <= mosi_d;
      wrm_q   <= wrm_d;
      wr_stb  <= wr_d;
      rd_stb  <= rd_d;
      inc_q   <= inc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    addr_d  = addr;
    mosi_d  = mosi;
    wrm_d   = wrm_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    inc_d   = 1'b0;
    rx_nxt  = {rx_q, mosi_s};
    // increment lands the clk after the write slot
    if (inc_q)
      addr_d = (addr + 8'd1) & ADDR_MASK;
    if (cs_rise) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_fall && armed) begin
            state_d = CMD;
            cnt_d   = '0;
            rx_d    = '0;
            tx_d    = '0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            rx_d  = rx_nxt[6:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LAST) begin
              state_d = DATA;
              cnt_d   = '0;
              addr_d  = rx_nxt & ADDR_MASK;
              wrm_d   = rx_nxt[CMD_WR_BIT];
            end
          end
        end
        DATA: begin
          if (sck_fall) begin
            if (cnt_q == '0) begin
              tx_d = rd_data;
              rd_d = 1'b1;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
          if (sck_rise) begin
            rx_d  = rx_nxt[6:0];
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == LAST) begin
              cnt_d = '0;
              inc_d = AUTO_INC;
              if (wrm_q) begin
                mosi_d = rx_nxt;
                wr_d   = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign miso    = tx_q[7];
  assign busy    = (state_q != IDLE);
  assign miso_oe = busy;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Randomised frame-level bench for spi_reg_slave with a
// transaction model plus directed literal checks.
module tb_spi_reg_slave;

  localparam bit AUTO_INC = 1'b1;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b0;
  logic cs_n = 1'b1;
  logic mosi_in = 1'b0;
  logic miso, miso_oe;
  logic [7:0] rd_data;
  logic [7:0] addr, mosi;
  logic wr_stb, rd_stb, busy;

  logic [7:0] rd_mem [128];
  logic [7:0] dbytes [4];
  logic [7:0] exp_wa[$];
  logic [7:0] exp_wd[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wr_log[$];
  logic [7:0] got_q[$];
  logic [7:0] addr_exp, mosi_exp;
  int wr_cnt, rd_cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd_data = rd_mem[addr[6:0]];

  spi_reg_slave #(
    .SYNC_STAGES(2),
    .AUTO_INC   (AUTO_INC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sck    (sck),
    .cs_n   (cs_n),
    .mosi_in(mosi_in),
    .miso   (miso),
    .miso_oe(miso_oe),
    .rd_data(rd_data),
    .addr   (addr),
    .mosi   (mosi),
    .wr_stb (wr_stb),
    .rd_stb (rd_stb),
    .busy   (busy)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] next_addr(input logic [7:0] a, input int k);
    if (!AUTO_INC) return a;
    return 8'((int'(a) + k) % 128);
  endfunction

  always @(negedge clk) begin
    if (rst_n && (wr_stb || rd_stb)) begin
      check("stb_excl", {31'd0, wr_stb & rd_stb}, 0);
      check("addr_b7", {31'd0, addr[7]}, 0);
    end
    if (rst_n && wr_stb) begin
      wr_cnt++;
      wr_log.push_back(addr);
      check("wr_expected", exp_wa.size(), 1 + 0 * exp_wa.size()
            + (exp_wa.size() > 1 ? exp_wa.size() - 1 : 0));
      if (exp_wa.size() != 0) begin
        check("wr_addr", addr, exp_wa.pop_front());
        check("wr_data", mosi, exp_wd.pop_front());
      end
    end
    if (rst_n && rd_stb) begin
      rd_cnt++;
      check("rd_expected", {31'd0, exp_rd.size() != 0}, 1);
      if (exp_rd.size() != 0)
        check("rd_addr", addr, exp_rd.pop_front());
    end
  end

  task automatic check_reset_vals();
    check("rst_addr", addr, 0);
    check("rst_mosi", mosi, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_rd_stb", rd_stb, 0);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic frame(input logic [7:0] cmd, input int nfull,
                       input int part);
    logic [7:0] a, ai, eb, db, acc;
    int total, m, j;
    a = cmd & 8'h7F;
    for (int k = 0; k < nfull + (part > 0 ? 1 : 0); k++) begin
      ai = next_addr(a, k);
      exp_rd.push_back(ai);
      if (k < nfull && cmd[7]) begin
        exp_wa.push_back(ai);
        exp_wd.push_back(dbytes[k]);
        mosi_exp = dbytes[k];
      end
    end
    addr_exp = next_addr(a, nfull);
    got_q.delete();
    acc = '0;
    cs_n = 1'b0;
    tick(2);
    check("busy_before", busy, 0);
    tick(1);
    check("busy_start", busy, 1);
    check("oe_start", miso_oe, 1);
    total = 8 + 8 * nfull + part;
    for (int k = 0; k < total; k++) begin
      m = 0;
      j = 0;
      if (k < 8) begin
        mosi_in = cmd[3'(7 - k)];
      end else begin
        m = (k - 8) / 8;
        j = (k - 8) % 8;
        db = dbytes[m];
        mosi_in = db[3'(7 - j)];
      end
      tick(HALF);
      if (k >= 8) begin
        ai = next_addr(a, m);
        eb = rd_mem[ai[6:0]];
        check("miso_bit", miso, eb[3'(7 - j)]);
        acc = {acc[6:0], miso};
        if (j == 7) got_q.push_back(acc);
      end
      sck = 1'b1;
      tick(HALF);
      if (k != total - 1) sck = 1'b0;
    end
    cs_n = 1'b1;
    tick(2);
    check("busy_hold", busy, 1);
    tick(1);
    check("busy_end", busy, 0);
    check("oe_end", miso_oe, 0);
    sck = 1'b0;
    tick(5);
    check("wr_left", exp_wa.size(), 0);
    check("rd_left", exp_rd.size(), 0);
    check("addr_end", addr, addr_exp);
    check("mosi_end", mosi, mosi_exp);
  endtask

  task automatic raw_bit(input logic b);
    mosi_in = b;
    tick(HALF);
    sck = 1'b1;
    tick(HALF);
    sck = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] c;
    int nf, pt;
    for (int i = 0; i < 128; i++) rd_mem[i] = 8'($urandom);
    addr_exp = '0;
    mosi_exp = '0;
    tick(3);
    check_reset_vals();
    rst_n = 1'b1;
    tick(10);

    wr_cnt = 0; rd_cnt = 0; wr_log.delete();
    dbytes[0] = 8'h5A;
    frame(8'hA3, 1, 0);
    check("w_wr_cnt", wr_cnt, 1);
    check("w_wr_addr", wr_log[0], 8'h23);
    check("w_mosi", mosi, 8'h5A);
    check("w_rd_cnt", rd_cnt, 1);
    tick(6);

    wr_cnt = 0; rd_cnt = 0;
    rd_mem[0] = 8'h12;
    dbytes[0] = 8'hFF;
    frame(8'h00, 1, 0);
    check("r_byte", got_q[0], 8'h12);
    check("r_rd_cnt", rd_cnt, 1);
    check("r_wr_cnt", wr_cnt, 0);
    tick(6);

    rd_cnt = 0;
    rd_mem[8'h26] = 8'hA1;
    rd_mem[8'h27] = 8'hB2;
    rd_mem[8'h28] = 8'hC3;
    frame(8'h26, 3, 0);
    check("b_byte0", got_q[0], 8'hA1);
    check("b_byte1", got_q[1], 8'hB2);
    check("b_byte2", got_q[2], 8'hC3);
    check("b_rd_cnt", rd_cnt, 3);
    check("b_addr", addr, 8'h29);
    tick(6);

    wr_log.delete();
    dbytes[0] = 8'h11;
    dbytes[1] = 8'h22;
    frame(8'hFF, 2, 0);
    check("wrap_a0", wr_log[0], 8'h7F);
    check("wrap_a1", wr_log[1], 8'h00);
    check("wrap_addr", addr, 8'h01);
    tick(6);

    wr_cnt = 0;
    dbytes[0] = 8'h77;
    frame(8'h85, 0, 5);
    check("ab_wr_cnt", wr_cnt, 0);
    check("ab_addr", addr, 8'h05);
    check("ab_mosi", mosi, 8'h22);
    tick(6);

    wr_cnt = 0;
    exp_rd.push_back(8'h05);
    cs_n = 1'b0;
    tick(5);
    c = 8'h85;
    for (int k = 0; k < 8; k++) raw_bit(c[3'(7 - k)]);
    for (int k = 0; k < 3; k++) raw_bit(1'b1);
    rst_n = 1'b0;
    tick(2);
    check_reset_vals();
    rst_n = 1'b1;
    for (int k = 0; k < 13; k++) raw_bit(1'b1);
    check("rm_busy", busy, 0);
    check("rm_wr_cnt", wr_cnt, 0);
    cs_n = 1'b1;
    tick(6);
    check("rm_addr", addr, 0);
    check("rm_mosi", mosi, 0);
    check("rm_rd_left", exp_rd.size(), 0);
    addr_exp = '0;
    mosi_exp = '0;

    for (int n = 0; n < 40; n++) begin
      c = 8'($urandom);
      nf = $urandom_range(0, 3);
      pt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < 4; i++) dbytes[i] = 8'($urandom);
      frame(c, nf, pt);
      tick($urandom_range(6, 12));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
